// File: rtl/shift_4.sv
// Parallel-load / serial-shift register, N bits wide (default 4). Optional SHIFT4_BIDIR_EN adds the Dir port for left shifts.
// Latency: 1 cycle. R, L, w (and Dir) are sampled at the rising Clock edge, and Q updates after that edge.
// Backpressure: none. Q changes on every edge by either a load or a shift, and Resetn clears Q asynchronously.
module shift_4 #(
    parameter int N = 4
) (
    input  logic         Clock,
    input  logic         Resetn,
    input  logic [N-1:0] R,
    input  logic         L,
    input  logic         w,
`ifdef SHIFT4_BIDIR_EN
    input  logic         Dir,
`endif
    output logic [N-1:0] Q
);

    logic [N-1:0] r_q;
    logic [N-1:0] w_shift;
    logic [N-1:0] w_next;

`ifdef SHIFT4_BIDIR_EN
    // Shifted value: right shift (w into MSB) or, with Dir high, left shift (w into LSB)
    always_comb begin
        w_shift = {w, r_q[N-1:1]};
        if (Dir) begin
            w_shift = {r_q[N-2:0], w};
        end
    end
`else
    // Shifted value: logical right shift with w entering the MSB
    always_comb begin
        w_shift = {w, r_q[N-1:1]};
    end
`endif

    // Next state: a parallel load takes priority over shifting, and there is no hold mode
    always_comb begin
        w_next = w_shift;
        if (L) begin
            w_next = R;
        end
    end

    // Single state register. Reset clears it without waiting for a clock edge.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    assign Q = r_q;

endmodule

// File: tb/tb_shift_4.sv
// Directed self-checking bench for shift_4 (default N = 4).
// Vectors are applied at the falling edge, and Q is sampled 1 ns after the rising edge.
// Define SHIFT4_BIDIR_EN on both files to also exercise left shifts.
module tb_shift_4;

    logic       Clock;
    logic       Resetn;
    logic [3:0] R;
    logic       L;
    logic       w;
    logic       Dir;
    logic [3:0] Q;

    int checks;
    int errors;

    shift_4 #(.N(4)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .R      (R),
        .L      (L),
        .w      (w),
`ifdef SHIFT4_BIDIR_EN
        .Dir    (Dir),
`endif
        .Q      (Q)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        string      name;
        logic       l;
        logic [3:0] r;
        logic       w;
        logic [3:0] exp_q;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic l, logic [3:0] r, logic wi, logic [3:0] e);
        vec_t v;
        v.name  = name;
        v.l     = l;
        v.r     = r;
        v.w     = wi;
        v.exp_q = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: Q=%b expected %b", name, act, exp);
        end
    endtask

    // Drive one operation at the falling edge, then sample Q just after the next rising edge.
    task automatic step(input logic l, input logic [3:0] r, input logic wi, input logic d);
        @(negedge Clock);
        L   = l;
        R   = r;
        w   = wi;
        Dir = d;
        @(posedge Clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Resetn = 1'b0;
        L   = 1'b0;
        R   = 4'b0000;
        w   = 1'b0;
        Dir = 1'b0;

        // Vector table: one rising edge per entry
        vecs.push_back(mk("load_1001",    1'b1, 4'b1001, 1'b0, 4'b1001));
        vecs.push_back(mk("load_0011",    1'b1, 4'b0011, 1'b0, 4'b0011));
        vecs.push_back(mk("load_0110",    1'b1, 4'b0110, 1'b0, 4'b0110));
        vecs.push_back(mk("load_1110",    1'b1, 4'b1110, 1'b0, 4'b1110));
        vecs.push_back(mk("load_1010",    1'b1, 4'b1010, 1'b0, 4'b1010));
        vecs.push_back(mk("drain_1",      1'b0, 4'b1111, 1'b0, 4'b0101));
        vecs.push_back(mk("drain_2",      1'b0, 4'b1111, 1'b0, 4'b0010));
        vecs.push_back(mk("drain_3",      1'b0, 4'b1111, 1'b0, 4'b0001));
        vecs.push_back(mk("drain_4",      1'b0, 4'b1111, 1'b0, 4'b0000));
        vecs.push_back(mk("drain_5",      1'b0, 4'b1111, 1'b0, 4'b0000));
        vecs.push_back(mk("load_0000",    1'b1, 4'b0000, 1'b1, 4'b0000));
        vecs.push_back(mk("fill_1",       1'b0, 4'b0000, 1'b1, 4'b1000));
        vecs.push_back(mk("fill_2",       1'b0, 4'b0000, 1'b1, 4'b1100));
        vecs.push_back(mk("fill_3",       1'b0, 4'b0000, 1'b1, 4'b1110));
        vecs.push_back(mk("fill_4",       1'b0, 4'b0000, 1'b1, 4'b1111));
        vecs.push_back(mk("load_prio",    1'b1, 4'b0011, 1'b1, 4'b0011));
        vecs.push_back(mk("toggle_shift", 1'b0, 4'b1100, 1'b0, 4'b0001));
        vecs.push_back(mk("toggle_load",  1'b1, 4'b0100, 1'b0, 4'b0100));
        vecs.push_back(mk("toggle_shw1",  1'b0, 4'b0000, 1'b1, 4'b1010));

        // Reset state. Q must stay zero across edges while Resetn is low, even with a load requested.
        #1;
        check("reset_init", Q, 4'b0000);
        step(1'b1, 4'b1111, 1'b1, 1'b0);
        check("reset_hold_edge", Q, 4'b0000);
        @(negedge Clock);
        Resetn = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].l, vecs[i].r, vecs[i].w, 1'b0);
            check(vecs[i].name, Q, vecs[i].exp_q);
        end

        // Asynchronous reset with no clock edge, starting from Q = 1011
        step(1'b1, 4'b1011, 1'b0, 1'b0);
        check("pre_async_1011", Q, 4'b1011);
        #2;
        Resetn = 1'b0;
        #1;
        check("async_reset", Q, 4'b0000);
        step(1'b1, 4'b1011, 1'b0, 1'b0);
        check("reset_hold_1", Q, 4'b0000);
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        check("reset_hold_2", Q, 4'b0000);
        @(negedge Clock);
        Resetn = 1'b1;

        // Reset in the middle of a shift sequence, followed by interleaved load and shift
        step(1'b1, 4'b1001, 1'b0, 1'b0);
        check("mid_load_1001", Q, 4'b1001);
        step(1'b0, 4'b0000, 1'b0, 1'b0);
        check("mid_shift", Q, 4'b0100);
        @(negedge Clock);
        Resetn = 1'b0;
        #1;
        check("mid_reset", Q, 4'b0000);
        #2;
        Resetn = 1'b1;
        step(1'b1, 4'b0110, 1'b0, 1'b0);
        check("post_reset_load", Q, 4'b0110);
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        check("post_reset_shift", Q, 4'b1011);

`ifdef SHIFT4_BIDIR_EN
        // Left shifts with Dir high, then a right shift with Dir low
        step(1'b1, 4'b1001, 1'b0, 1'b1);
        check("bidir_load", Q, 4'b1001);
        step(1'b0, 4'b0000, 1'b0, 1'b1);
        check("bidir_left_1", Q, 4'b0010);
        step(1'b0, 4'b0000, 1'b0, 1'b1);
        check("bidir_left_2", Q, 4'b0100);
        step(1'b0, 4'b0000, 1'b1, 1'b0);
        check("bidir_right", Q, 4'b1010);
        step(1'b1, 4'b0110, 1'b1, 1'b1);
        check("bidir_load_prio", Q, 4'b0110);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
